// File: rtl/fp16_mul_result_stage.sv
// Registered result stage behind the FP16 multiplier: in-order FIFO with
// per-entry IEEE flags, valid/ready output and sticky CSR flags.
module fp16_mul_result_stage #(
    parameter int DEPTH = 2,
    parameter int TAG_W = 4
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [TAG_W-1:0]           in_tag,
    input  logic [15:0]                in_float1,
    input  logic [15:0]                in_float2,
    input  logic [15:0]                in_product,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [TAG_W-1:0]           out_tag,
    output logic [15:0]                out_product,
    output logic [4:0]                 out_flags,
    output logic [4:0]                 fflags,
    input  logic                       fflags_clr,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [15:0]      prod;
        logic [4:0]       flags;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [4:0]      fflags_q, fflags_d;
    entry_t          head;
    entry_t          new_entry;
    logic            push, pop;
    logic            nv, of, uf;

    function automatic logic is_snan(input logic [15:0] x);
        return (x[14:10] == 5'h1F) && (|x[9:0]) && !x[9];
    endfunction

    function automatic logic is_inf(input logic [15:0] x);
        return (x[14:10] == 5'h1F) && !(|x[9:0]);
    endfunction

    function automatic logic is_zero(input logic [15:0] x);
        return !(|x[14:0]);
    endfunction

    function automatic logic is_fin(input logic [15:0] x);
        return x[14:10] != 5'h1F;
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign in_ready = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push = in_valid && in_ready;
    assign pop = out_valid && out_ready;
    assign head = mem_q[rd_ptr_q];

    // Flags come from operand classes; the product only tells magnitude.
    always_comb begin
        nv = is_snan(in_float1) | is_snan(in_float2)
           | (is_inf(in_float1) & is_zero(in_float2))
           | (is_zero(in_float1) & is_inf(in_float2));
        of = is_fin(in_float1) & is_fin(in_float2)
           & (in_product[14:10] == 5'h1F);
        uf = is_fin(in_float1) & is_fin(in_float2)
           & !is_zero(in_float1) & !is_zero(in_float2)
           & (in_product[14:10] == 5'h00);
        new_entry.tag = in_tag;
        new_entry.prod = in_product;
        new_entry.flags = {nv, 1'b0, of, uf, of | uf};
    end

    always_comb begin
        mem_d = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = new_entry;
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        fflags_d = (fflags_clr ? 5'b0 : fflags_q) | (pop ? head.flags : 5'b0);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q <= '0;
            fflags_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q <= count_d;
            fflags_q <= fflags_d;
        end
    end

    assign out_tag = head.tag;
    assign out_product = head.prod;
    assign out_flags = head.flags;
    assign fflags = fflags_q;
    assign count = count_q;

endmodule

// File: tb/tb_fp16_mul_result_stage.sv
// Scoreboard bench for fp16_mul_result_stage: directed scenarios, results
// checked in order as they leave the stage.
module tb_fp16_mul_result_stage;

    logic        CLK;
    logic        nRST;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_tag;
    logic [15:0] in_float1;
    logic [15:0] in_float2;
    logic [15:0] in_product;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_tag;
    logic [15:0] out_product;
    logic [4:0]  out_flags;
    logic [4:0]  fflags;
    logic        fflags_clr;
    logic [1:0]  count;

    int total = 0;
    int bad = 0;
    int max_count = 0;
    logic [24:0] sb [$];

    fp16_mul_result_stage #(.DEPTH(2), .TAG_W(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag),
        .in_float1(in_float1), .in_float2(in_float2), .in_product(in_product),
        .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
        .out_product(out_product), .out_flags(out_flags),
        .fflags(fflags), .fflags_clr(fflags_clr), .count(count)
    );

    initial begin
        CLK = 0;
        forever #5 CLK = ~CLK;
    end

    // Scoreboard: every pop must match the oldest expected result.
    always @(negedge CLK) begin
        if (nRST) begin
            if (int'(count) > max_count) max_count = int'(count);
            if (out_valid && out_ready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected_pop got=%h", {out_tag, out_product, out_flags});
                end else begin
                    logic [24:0] exp_e;
                    exp_e = sb.pop_front();
                    if ({out_tag, out_product, out_flags} !== exp_e) begin
                        bad++;
                        $display("FAIL sb_pop got=%h exp=%h", {out_tag, out_product, out_flags}, exp_e);
                    end
                end
            end
        end
    end

    task automatic push(input logic [3:0] t, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] p,
                        input logic [4:0] fl);
        logic acc;
        acc = 0;
        in_valid = 1; in_tag = t; in_float1 = a; in_float2 = b; in_product = p;
        sb.push_back({t, p, fl});
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge CLK);
            acc = in_ready;
            @(posedge CLK); #1;
        end
        in_valid = 0;
        if (!acc) begin
            total++; bad++;
            $display("FAIL push_timeout tag=%0d", t);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_reset;
        nRST = 1;
        #1 nRST = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK); #1;
            in_valid = 1'($urandom); in_tag = 4'($urandom);
            in_float1 = 16'($urandom); in_float2 = 16'($urandom);
            in_product = 16'($urandom); out_ready = 1'($urandom);
            fflags_clr = 1'($urandom);
        end
        @(negedge CLK);
        total++;
        if ({out_valid, fflags, count} !== 8'b0) begin
            bad++;
            $display("FAIL reset_state got=%b exp=0", {out_valid, fflags, count});
        end
        total++;
        if ({out_tag, out_product, out_flags} !== 25'b0) begin
            bad++;
            $display("FAIL reset_out got=%h exp=0", {out_tag, out_product, out_flags});
        end
        @(posedge CLK); #1;
        in_valid = 0; out_ready = 0; fflags_clr = 0;
        nRST = 1;
        @(negedge CLK);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_basic;
        out_ready = 1;
        push(4'd3, 16'h3C00, 16'h4000, 16'h4000, 5'b00000);
        @(negedge CLK);
        total++;
        if ({out_valid, out_tag, out_product, out_flags} !== {1'b1, 4'd3, 16'h4000, 5'b0}) begin
            bad++;
            $display("FAIL basic_out got=%h exp=%h",
                     {out_valid, out_tag, out_product, out_flags}, {1'b1, 4'd3, 16'h4000, 5'b0});
        end
        @(posedge CLK); #1;
        @(negedge CLK);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_drain got=%b exp=0", out_valid);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_overflow;
        out_ready = 0;
        push(4'd5, 16'h7BFF, 16'h7BFF, 16'h7C00, 5'b00101);
        @(negedge CLK);
        total++;
        if (out_flags !== 5'b00101) begin
            bad++;
            $display("FAIL ovf_flags got=%b exp=00101", out_flags);
        end
        @(posedge CLK); #1;
        out_ready = 1;
        cyc(1);
        out_ready = 0;
        @(negedge CLK);
        total++;
        if ({fflags, count} !== {5'b00101, 2'd0}) begin
            bad++;
            $display("FAIL ovf_fflags got=%b exp=%b", {fflags, count}, {5'b00101, 2'd0});
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_invalid;
        out_ready = 1;
        push(4'd6, 16'h7C00, 16'h0000, 16'hFFFF, 5'b10000);
        push(4'd7, 16'h7C01, 16'h3C00, 16'h7E01, 5'b10000);
        push(4'd8, 16'h0000, 16'h0000, 16'h0000, 5'b00000);
        push(4'd9, 16'h7E00, 16'h3C00, 16'h7E00, 5'b00000);
        cyc(2);
        @(negedge CLK);
        total++;
        if (fflags !== 5'b10101) begin
            bad++;
            $display("FAIL inv_fflags got=%b exp=10101", fflags);
        end
        @(posedge CLK); #1;
        out_ready = 0;
        fflags_clr = 1;
        cyc(1);
        fflags_clr = 0;
        @(negedge CLK);
        total++;
        if (fflags !== 5'b0) begin
            bad++;
            $display("FAIL clr_no_pop got=%b exp=00000", fflags);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_backpressure;
        logic acc;
        out_ready = 0;
        max_count = 0;
        push(4'd1, 16'h3C00, 16'h3C00, 16'h3C00, 5'b0);
        push(4'd2, 16'h3C00, 16'h3C00, 16'h3C00, 5'b0);
        in_valid = 1; in_tag = 4'd3;
        sb.push_back({4'd3, 16'h3C00, 5'b0});
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            total++;
            if ({in_ready, count} !== {1'b0, 2'd2}) begin
                bad++;
                $display("FAIL bp_full got=%b exp=010", {in_ready, count});
            end
            @(posedge CLK); #1;
        end
        out_ready = 1;
        acc = 0;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge CLK);
            acc = in_ready;
            @(posedge CLK); #1;
        end
        in_valid = 0;
        for (int i = 0; i < 20 && sb.size() != 0; i++) cyc(1);
        total++;
        if (!acc || sb.size() != 0) begin
            bad++;
            $display("FAIL bp_drain acc=%b left=%0d exp_left=0", acc, sb.size());
        end
        total++;
        if (max_count > 2) begin
            bad++;
            $display("FAIL bp_max_count got=%0d exp<=2", max_count);
        end
        out_ready = 0;
    endtask

    task automatic test_clear_reset;
        out_ready = 1;
        push(4'hA, 16'h7BFF, 16'h7BFF, 16'h7C00, 5'b00101);
        cyc(1);
        out_ready = 0;
        @(negedge CLK);
        total++;
        if (fflags !== 5'b00101) begin
            bad++;
            $display("FAIL cr_pre got=%b exp=00101", fflags);
        end
        @(posedge CLK); #1;
        push(4'hB, 16'h0400, 16'h0400, 16'h0000, 5'b00011);
        out_ready = 1;
        fflags_clr = 1;
        cyc(1);
        out_ready = 0;
        fflags_clr = 0;
        @(negedge CLK);
        total++;
        if (fflags !== 5'b00011) begin
            bad++;
            $display("FAIL cr_clr_pop got=%b exp=00011", fflags);
        end
        @(posedge CLK); #1;
        push(4'hC, 16'h3C00, 16'h3C00, 16'h3C00, 5'b0);
        push(4'hD, 16'h3C00, 16'h3C00, 16'h3C00, 5'b0);
        @(negedge CLK);
        total++;
        if (count !== 2'd2) begin
            bad++;
            $display("FAIL cr_queued got=%0d exp=2", count);
        end
        #2 nRST = 0;
        #1;
        sb.delete();
        total++;
        if ({count, out_valid, fflags} !== 8'b0) begin
            bad++;
            $display("FAIL cr_async_rst got=%b exp=0", {count, out_valid, fflags});
        end
        @(posedge CLK); #1;
        nRST = 1;
        @(negedge CLK);
        total++;
        if ({in_ready, out_valid} !== 2'b10) begin
            bad++;
            $display("FAIL cr_after_rst got=%b exp=10", {in_ready, out_valid});
        end
    endtask

    initial begin
        in_valid = 0; in_tag = 0; in_float1 = 0; in_float2 = 0;
        in_product = 0; out_ready = 0; fflags_clr = 0;
        test_reset();
        test_basic();
        test_overflow();
        test_invalid();
        test_backpressure();
        test_clear_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
